// File: rtl/zint_pkg.sv
// Shared constants for the ZX-bus interrupt controller: register map,
// CONTROL bit positions and the /INT pulse state encoding.
package zint_pkg;

   // Register select values on cfg_addr
   localparam logic [1:0] ZINT_ENABLE  = 2'd0;
   localparam logic [1:0] ZINT_EDGE    = 2'd1;
   localparam logic [1:0] ZINT_PENDING = 2'd2;
   localparam logic [1:0] ZINT_CONTROL = 2'd3;

   // CONTROL register bit positions
   localparam int CTRL_GEN    = 0;
   localparam int CTRL_PULSE  = 1;
   localparam int CTRL_VEC_LO = 4;

   // /INT driver state: idle, driving the pulse, waiting for the request to drop
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_WAIT  = 2'd2
   } pulse_state_t;

endpackage

// File: rtl/zint_sync.sv
// Per-bit synchroniser for raw interrupt lines with polarity normalisation
// and rising-edge detect on the synchronised value.
module zint_sync
   import zint_pkg::*;
#(
   parameter int             W      = 2,
   parameter int             STAGES = 2,
   parameter logic [W-1:0]   POL    = '0
) (
   input  logic         fclk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] s,
   output logic [W-1:0] rise
);

   logic [W-1:0] chain [STAGES];
   logic [W-1:0] prev;

   // Shift the normalised (1 = active) inputs through the synchroniser chain
   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) chain[k] <= '0;
         prev <= '0;
      end else begin
         chain[0] <= din ^ POL;
         for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
         prev <= chain[STAGES-1];
      end
   end

   assign s    = chain[STAGES-1];
   assign rise = s & ~prev;

endmodule

// File: rtl/zint_ctrl.sv
// ZX-bus interrupt controller: latches edge/level events per source, masks
// them, and drives the /INT request either as a level or a fixed pulse.
// CPU side: cfg_we is a single-cycle write strobe with no back-pressure; the
// write takes effect on the fclk edge that samples it. Reads are combinational.
module zint_ctrl
   import zint_pkg::*;
#(
   parameter int                NSRC        = 2,
   parameter logic [NSRC-1:0]   SRC_POL     = NSRC'(2'b01),
   parameter int                SYNC_STAGES = 2,
   parameter int                PULSE_LEN   = 32
) (
   input  logic            fclk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] src_in,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_addr,
   input  logic [7:0]      cfg_wdata,
   output logic [7:0]      cfg_rdata,
   output logic            int_req,
   output logic            zint_oe,
   output logic [2:0]      irq_vec,
   output logic [1:0]      dbg_state
);

   localparam logic [7:0] PULSE_INIT = 8'(PULSE_LEN - 1);

   logic [NSRC-1:0] s, rise;
   logic [NSRC-1:0] enable_r, edge_r, pending_r;
   logic [NSRC-1:0] active, clr;
   logic            gen_r, pulse_r;
   logic [2:0]      irq_vec_c;
   logic            gated, ctrl_wr, abort;
   logic [7:0]      cnt;
   pulse_state_t    state;

   zint_sync #(
      .W      (NSRC),
      .STAGES (SYNC_STAGES),
      .POL    (SRC_POL)
   ) u_sync (
      .fclk  (fclk),
      .rst_n (rst_n),
      .din   (src_in),
      .s     (s),
      .rise  (rise)
   );

   assign clr     = (cfg_we && cfg_addr == ZINT_PENDING) ? cfg_wdata[NSRC-1:0] : '0;
   assign ctrl_wr = cfg_we && cfg_addr == ZINT_CONTROL;
   // Turning GEN off or switching mode restarts the driver from idle
   assign abort   = ctrl_wr && (!cfg_wdata[CTRL_GEN] || (cfg_wdata[CTRL_PULSE] != pulse_r));

   // CPU-writable configuration registers
   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         enable_r <= '0;
         edge_r   <= '0;
         gen_r    <= 1'b0;
         pulse_r  <= 1'b0;
      end else if (cfg_we) begin
         case (cfg_addr)
            ZINT_ENABLE:  enable_r <= cfg_wdata[NSRC-1:0];
            ZINT_EDGE:    edge_r   <= cfg_wdata[NSRC-1:0];
            ZINT_CONTROL: begin
               gen_r   <= cfg_wdata[CTRL_GEN];
               pulse_r <= cfg_wdata[CTRL_PULSE];
            end
            default: ;
         endcase
      end
   end

   // Pending latch: edge sources hold until cleared (a new edge wins), level sources track s
   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         pending_r <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (edge_r[i]) begin
               if (rise[i])     pending_r[i] <= 1'b1;
               else if (clr[i]) pending_r[i] <= 1'b0;
            end else begin
               pending_r[i] <= s[i];
            end
         end
      end
   end

   assign active  = pending_r & enable_r;
   assign int_req = |active;
   assign gated   = int_req & gen_r;

   // Lowest-numbered active source wins
   always_comb begin
      irq_vec_c = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) irq_vec_c = 3'(i);
      end
   end

   assign irq_vec = irq_vec_c;

   // Register read mux; bits above NSRC read as zero
   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         ZINT_ENABLE:  cfg_rdata = 8'(enable_r);
         ZINT_EDGE:    cfg_rdata = 8'(edge_r);
         ZINT_PENDING: cfg_rdata = 8'(pending_r);
         ZINT_CONTROL: begin
            cfg_rdata[CTRL_GEN]                 = gen_r;
            cfg_rdata[CTRL_PULSE]               = pulse_r;
            cfg_rdata[CTRL_VEC_LO+2:CTRL_VEC_LO] = irq_vec_c;
         end
         default: cfg_rdata = '0;
      endcase
   end

   // /INT driver: level follows gated one cycle late, pulse mode emits PULSE_LEN cycles per rising request
   always_ff @(posedge fclk) begin
      if (!rst_n || abort) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         zint_oe <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pulse_r) begin
                  if (gated) begin
                     state   <= ST_PULSE;
                     cnt     <= PULSE_INIT;
                     zint_oe <= 1'b1;
                  end else begin
                     zint_oe <= 1'b0;
                  end
               end else begin
                  zint_oe <= gated;
               end
            end
            ST_PULSE: begin
               if (cnt == 8'd0) begin
                  state   <= ST_WAIT;
                  zint_oe <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            ST_WAIT: begin
               zint_oe <= 1'b0;
               if (!gated) state <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               zint_oe <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule
